input_debouncer: RTL and testbench

Upstream conditioning stage for the edgeDetector block. Synchronises a raw asynchronous input (button, switch, external strobe) into clk and rejects bounce and glitches. Produces a clean, stable level, out_level, which drives edgeDetector.in_edge. Also reports qualification activity and keeps a saturating count of rejected glitches for debug.

---
 rtl/input_debouncer.sv | 126 ++++++++++++
 tb/tb_input_debouncer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Two-level input conditioner: synchronises an asynchronous input into clk, then
// accepts a new level only after STABLE_CYCLES matching samples, counting rejected bounces.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_raw,
  input  logic                glitch_clr,
  output logic                out_level,
  output logic                out_busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   reject;
  logic                   s;

  // Synchroniser chain; only its last stage is visible to the qualifier.
  assign sync_d[0] = in_raw;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    reject  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = QUAL_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          reject  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = QUAL_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          reject  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear has priority over a same-cycle rejection; the count saturates.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (reject && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      glitch_q <= glitch_d;
    end
  end

  assign out_level  = level_q;
  assign out_busy   = (state_q == QUAL_HI) || (state_q == QUAL_LO);
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed and randomized checks of input_debouncer against a run-length reference model.
module tb_input_debouncer;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int GLITCH_W      = 8;
  localparam int GMAX          = (1 << GLITCH_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_raw = 1'b0;
  logic                glitch_clr = 1'b0;
  logic                out_level;
  logic                out_busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  input_debouncer #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .GLITCH_W(GLITCH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_raw(in_raw),
    .glitch_clr(glitch_clr),
    .out_level(out_level),
    .out_busy(out_busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: delayed raw samples, accepted level, length of the current
  // run of samples disagreeing with it, and the glitch tally.
  bit raw_m[$];
  bit level_m = 1'b0;
  int run_m = 0;
  int glitch_m = 0;
  int rise_m = 0, fall_m = 0;
  int rise_dut = 0, fall_dut = 0;
  logic prev_level = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit s;
    bit rej;
    if (rst) begin
      raw_m = {};
      for (int i = 0; i < SYNC_STAGES; i++) raw_m.push_back(1'b0);
      level_m  = 1'b0;
      run_m    = 0;
      glitch_m = 0;
    end else begin
      s = raw_m.pop_front();
      raw_m.push_back(in_raw);
      rej = 1'b0;
      if (s != level_m) begin
        run_m++;
        if (run_m == STABLE_CYCLES) begin
          level_m = s;
          run_m   = 0;
          if (s) rise_m++;
          else fall_m++;
        end
      end else if (run_m > 0) begin
        run_m = 0;
        rej   = 1'b1;
      end
      if (glitch_clr) glitch_m = 0;
      else if (rej && glitch_m < GMAX) glitch_m++;
    end
  endtask

  // One clock edge: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (prev_level === 1'b0 && out_level === 1'b1) rise_dut++;
    if (prev_level === 1'b1 && out_level === 1'b0) fall_dut++;
    prev_level = out_level;
    chk("out_level", 32'(out_level), 32'(level_m));
    chk("out_busy", 32'(out_busy), 32'(run_m > 0));
    chk("glitch_cnt", 32'(glitch_cnt), 32'(glitch_m));
  endtask

  // Drive a new level and hold it for 20 edges; report edges until out_level
  // follows and how many sampled cycles showed out_busy.
  task automatic hold_level(input bit v, output int lat, output int busy);
    lat  = 0;
    busy = 0;
    in_raw = v;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_busy === 1'b1) busy++;
      if (lat == 0 && out_level === v) lat = i;
    end
  endtask

  initial begin
    int lat, busy, off_cnt, r0, f0, nb, segs_hi, segs_lo;
    bit v;

    // Reset with in_raw high, then release: full-latency rise.
    in_raw = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      step();
      chk("rst_level", 32'(out_level), 32'd0);
      chk("rst_busy", 32'(out_busy), 32'd0);
      chk("rst_glitch", 32'(glitch_cnt), 32'd0);
    end
    rst = 1'b0;
    hold_level(1'b1, lat, busy);
    chk("post_rst_rise_latency", 32'(lat), 32'(SYNC_STAGES + STABLE_CYCLES));
    chk("post_rst_rise_busy", 32'(busy), 32'(STABLE_CYCLES - 1));

    // Clean fall, rise, fall.
    hold_level(1'b0, lat, busy);
    chk("fall_latency", 32'(lat), 32'd6);
    chk("fall_busy", 32'(busy), 32'd3);
    hold_level(1'b1, lat, busy);
    chk("rise_latency", 32'(lat), 32'd6);
    chk("rise_busy", 32'(busy), 32'd3);
    hold_level(1'b0, lat, busy);
    chk("fall2_latency", 32'(lat), 32'd6);
    chk("clean_glitch", 32'(glitch_cnt), 32'd0);

    // Two-cycle high glitch while low.
    busy = 0; off_cnt = 0;
    in_raw = 1'b1;
    repeat (2) begin step(); if (out_busy === 1'b1) busy++; if (out_level !== 1'b0) off_cnt++; end
    in_raw = 1'b0;
    repeat (8) begin step(); if (out_busy === 1'b1) busy++; if (out_level !== 1'b0) off_cnt++; end
    chk("lo_glitch_busy", 32'(busy), 32'd2);
    chk("lo_glitch_level_moves", 32'(off_cnt), 32'd0);
    chk("lo_glitch_cnt", 32'(glitch_cnt), 32'd1);

    // Three-cycle low pulse while high: one short of qualifying.
    hold_level(1'b1, lat, busy);
    busy = 0; off_cnt = 0;
    in_raw = 1'b0;
    repeat (3) begin step(); if (out_busy === 1'b1) busy++; if (out_level !== 1'b1) off_cnt++; end
    in_raw = 1'b1;
    repeat (8) begin step(); if (out_busy === 1'b1) busy++; if (out_level !== 1'b1) off_cnt++; end
    chk("hi_glitch_busy", 32'(busy), 32'd3);
    chk("hi_glitch_level_moves", 32'(off_cnt), 32'd0);
    chk("hi_glitch_cnt", 32'(glitch_cnt), 32'd2);

    // Saturation.
    hold_level(1'b0, lat, busy);
    for (int i = 0; i < 260; i++) begin
      in_raw = 1'b1;
      step();
      in_raw = 1'b0;
      repeat (4) step();
    end
    chk("glitch_saturated", 32'(glitch_cnt), 32'd255);

    // Clear coincides with a rejection: clear wins.
    in_raw = 1'b1;
    step();
    in_raw = 1'b0;
    step();
    step();
    chk("pre_clear_busy", 32'(out_busy), 32'd1);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    chk("clear_wins", 32'(glitch_cnt), 32'd0);
    chk("clear_busy", 32'(out_busy), 32'd0);

    // Reset in the middle of a qualification.
    in_raw = 1'b1;
    step();
    in_raw = 1'b0;
    repeat (4) step();
    chk("pre_rst_glitch", 32'(glitch_cnt), 32'd1);
    in_raw = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    in_raw = 1'b0;
    step();
    rst = 1'b0;
    chk("midq_rst_level", 32'(out_level), 32'd0);
    chk("midq_rst_busy", 32'(out_busy), 32'd0);
    chk("midq_rst_glitch", 32'(glitch_cnt), 32'd0);
    repeat (6) step();
    chk("midq_after_glitch", 32'(glitch_cnt), 32'd0);
    chk("midq_after_level", 32'(out_level), 32'd0);

    // Random bouncy transitions around stable levels.
    r0 = rise_dut; f0 = fall_dut;
    rise_m = 0; fall_m = 0;
    segs_hi = 0; segs_lo = 0;
    v = 1'b0;
    for (int seg = 0; seg < 25; seg++) begin
      v = ~v;
      nb = int'($urandom_range(0, 3));
      for (int b = 0; b < nb; b++) begin
        in_raw = v;
        repeat ($urandom_range(1, 3)) step();
        in_raw = ~v;
        repeat ($urandom_range(1, 3)) step();
      end
      in_raw = v;
      repeat (20) step();
      chk("seg_level", 32'(out_level), 32'(v));
      if (v) segs_hi++;
      else segs_lo++;
    end
    chk("rand_rises", 32'(rise_dut - r0), 32'(segs_hi));
    chk("rand_falls", 32'(fall_dut - f0), 32'(segs_lo));
    chk("model_rises", 32'(rise_dut - r0), 32'(rise_m));
    chk("model_falls", 32'(fall_dut - f0), 32'(fall_m));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
